sync_fifo: RTL and testbench

- Synchronous valid/ready FIFO that sits directly downstream of the fixed-latency register delay line.
- Absorbs the delay line's output stream and decouples it from a consumer that may stall.
- Show-ahead (first-word-fall-through) output; single clock domain.
- Upstream side accepts a word per cycle while not full; downstream side presents the head word whenever not empty.

---
 rtl/sync_fifo_if.sv | 31 +++
 rtl/sync_fifo.sv | 88 ++++++++
 tb/tb_sync_fifo.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_if.sv
// Valid/ready handshake bundle between a producer, the sync_fifo and its consumer.
// The slave modport is the FIFO's view; the master modport is the view of the
// environment that feeds the FIFO and drains it.
interface sync_fifo_if #(
    parameter int WIDTH = 8
);
    logic             i_valid;
    logic [WIDTH-1:0] i_data;
    logic             o_ready;
    logic             o_valid;
    logic [WIDTH-1:0] o_data;
    logic             i_ready;

    modport slave (
        input  i_valid,
        input  i_data,
        input  i_ready,
        output o_ready,
        output o_valid,
        output o_data
    );

    modport master (
        output i_valid,
        output i_data,
        output i_ready,
        input  o_ready,
        input  o_valid,
        input  o_data
    );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead valid/ready FIFO that absorbs a delay line's output
// stream and decouples it from a consumer that may stall.
// All outputs decode from registered state only, so there is no combinational
// path from i_ready to o_ready or from i_valid to o_valid.
// Optional macro SYNC_FIFO_LEVEL_EN adds an o_level port equal to the occupancy.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    sync_fifo_if.slave               bus
`ifdef SYNC_FIFO_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0]   o_level
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push, pop;
    logic [DEPTH-1:0] wr_en;

    // Status and head word come straight from registered state.
    assign bus.o_valid = (count_q != '0);
    assign bus.o_ready = (count_q != CW'(DEPTH));
    assign bus.o_data  = mem_q[rd_ptr_q];

    assign push = bus.i_valid && bus.o_ready;
    assign pop  = bus.o_valid && bus.i_ready;

`ifdef SYNC_FIFO_LEVEL_EN
    assign o_level = count_q;
`endif

    // One write-enable per storage entry, selected by the write pointer.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = push && (wr_ptr_q == AW'(gi));
        end
    endgenerate

    // Next-state for pointers and occupancy; pointers wrap by natural overflow.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // Control registers; reset discards any stored words regardless of handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; entries clear on reset so o_data reads zero when idle.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst) begin
                mem_q[i] <= '0;
            end else if (wr_en[i]) begin
                mem_q[i] <= bus.i_data;
            end
        end
    end
endmodule

// File: tb/tb_sync_fifo.sv
// Directed testbench for sync_fifo (WIDTH=8, DEPTH=4).
module tb_sync_fifo;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    sync_fifo_if #(.WIDTH(8)) bus ();

`ifdef SYNC_FIFO_LEVEL_EN
    logic [2:0] level;
    sync_fifo #(.WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave), .o_level(level)
    );
`else
    sync_fifo #(.WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );
`endif

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %0d %s observed=%0h expected=%0h", checks, tag, obs, exp);
    endtask

    task automatic check_level(input string tag, input int exp);
`ifdef SYNC_FIFO_LEVEL_EN
        check(tag, 32'(level), 32'(exp));
`endif
    endtask

    task automatic push_word(input logic [7:0] d);
        bus.i_valid = 1'b1;
        bus.i_data  = d;
        bus.i_ready = 1'b0;
        step();
        bus.i_valid = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_data  = 8'hEE;
        bus.i_ready = 1'b1;

        // Reset then idle
        step();
        step();
        rst         = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;
        #1;
        check("rst_valid", 32'(bus.o_valid), 32'd0);
        check("rst_ready", 32'(bus.o_ready), 32'd1);
        check("rst_data",  32'(bus.o_data),  32'h00);
        check_level("rst_level", 0);

        // Single word, one-cycle latency
        push_word(8'hA5);
        check("single_valid", 32'(bus.o_valid), 32'd1);
        check("single_data",  32'(bus.o_data),  32'hA5);
        check_level("single_level", 1);
        bus.i_ready = 1'b1;
        step();
        bus.i_ready = 1'b0;
        check("single_empty", 32'(bus.o_valid), 32'd0);

        // Fill to full
        for (int k = 1; k <= 4; k++) begin
            push_word(8'(k));
        end
        check("full_ready", 32'(bus.o_ready), 32'd0);
        check("full_head",  32'(bus.o_data),  32'h01);
        check_level("full_level", 4);
        bus.i_valid = 1'b1;
        bus.i_data  = 8'h05;
        for (int k = 0; k < 3; k++) begin
            step();
            check("hold_ready", 32'(bus.o_ready), 32'd0);
            check("hold_head",  32'(bus.o_data),  32'h01);
        end
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check("drain_valid", 32'(bus.o_valid), 32'd1);
            check("drain_data",  32'(bus.o_data),  32'(k));
            step();
        end
        check("drain_empty", 32'(bus.o_valid), 32'd0);

        // Streaming 00..FF at one word per cycle
        bus.i_valid = 1'b1;
        bus.i_ready = 1'b1;
        for (int k = 0; k < 256; k++) begin
            bus.i_data = 8'(k);
            step();
            check("stream_valid", 32'(bus.o_valid), 32'd1);
            check("stream_data",  32'(bus.o_data),  32'(k));
            check_level("stream_level", 1);
        end
        bus.i_valid = 1'b0;
        step();
        check("stream_end", 32'(bus.o_valid), 32'd0);

        // Full with simultaneous pop and push attempt
        for (int k = 5; k <= 8; k++) begin
            push_word(8'(k));
        end
        check("full2_ready", 32'(bus.o_ready), 32'd0);
        bus.i_valid = 1'b1;
        bus.i_data  = 8'h09;
        bus.i_ready = 1'b1;
        step();
        check("fullpop_head",  32'(bus.o_data),  32'h06);
        check("fullpop_ready", 32'(bus.o_ready), 32'd1);
        check_level("fullpop_level", 3);
        bus.i_ready = 1'b0;
        step();
        check("refill_ready", 32'(bus.o_ready), 32'd0);
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        for (int k = 6; k <= 9; k++) begin
            check("drain2_valid", 32'(bus.o_valid), 32'd1);
            check("drain2_data",  32'(bus.o_data),  32'(k));
            step();
        end
        check("drain2_empty", 32'(bus.o_valid), 32'd0);

        // Reset mid-operation with count=3
        push_word(8'h11);
        push_word(8'h22);
        push_word(8'h33);
        check_level("pre_rst_level", 3);
        rst         = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_data  = 8'h44;
        bus.i_ready = 1'b1;
        step();
        rst         = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;
        #1;
        check("midrst_valid", 32'(bus.o_valid), 32'd0);
        check("midrst_ready", 32'(bus.o_ready), 32'd1);
        check("midrst_data",  32'(bus.o_data),  32'h00);
        check_level("midrst_level", 0);
        push_word(8'h3C);
        check("after_rst_valid", 32'(bus.o_valid), 32'd1);
        check("after_rst_data",  32'(bus.o_data),  32'h3C);
        bus.i_ready = 1'b1;
        step();
        bus.i_ready = 1'b0;
        check("after_rst_empty", 32'(bus.o_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
